// File: rtl/binary_aggregator_sched.sv
// Slot scheduler that runs compare rounds through an external binary aggregator tree.
// Define BA_SCHED_FLUSH_EN to add the synchronous flush input.
module binary_aggregator_sched #(
   parameter int CANDIDATE_CNT = 5,
   parameter int KEY_WIDTH     = 6,
   parameter int DATA_WIDTH    = 16,
   parameter int IDX_WIDTH     = 3,
   parameter int AGG_LATENCY   = 0
) (
   input  logic                                             clk,
   input  logic                                             rst_n,
   input  logic [CANDIDATE_CNT-1:0]                         req_vld,
   input  logic [CANDIDATE_CNT*KEY_WIDTH-1:0]               req_key,
   input  logic [CANDIDATE_CNT*DATA_WIDTH-1:0]              req_data,
   output logic [CANDIDATE_CNT-1:0]                         req_rdy,
   output logic [CANDIDATE_CNT-1:0]                         agg_cand_vld,
   output logic [CANDIDATE_CNT*KEY_WIDTH-1:0]               agg_cand_key,
   output logic [CANDIDATE_CNT*(DATA_WIDTH+IDX_WIDTH)-1:0]  agg_cand_data,
   input  logic                                             agg_win_vld,
   input  logic [KEY_WIDTH-1:0]                             agg_win_key,
   input  logic [DATA_WIDTH+IDX_WIDTH-1:0]                  agg_win_data,
   output logic                                             out_vld,
   output logic [KEY_WIDTH-1:0]                             out_key,
   output logic [DATA_WIDTH-1:0]                            out_data,
   output logic [IDX_WIDTH-1:0]                             out_idx,
   input  logic                                             out_rdy,
`ifdef BA_SCHED_FLUSH_EN
   input  logic                                             flush,
`endif
   output logic [CANDIDATE_CNT-1:0]                         slot_vld,
   output logic                                             sched_err
);

   localparam int CW    = DATA_WIDTH + IDX_WIDTH;
   localparam int CNT_W = (AGG_LATENCY > 0) ? $clog2(AGG_LATENCY + 1) : 1;
   localparam logic [CNT_W-1:0]   CNT_LOAD  = CNT_W'(AGG_LATENCY);
   localparam logic [CNT_W-1:0]   CNT_ONE   = CNT_W'(1);
   localparam logic [IDX_WIDTH:0] IDX_LIMIT = (IDX_WIDTH+1)'(CANDIDATE_CNT);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EVAL = 2'd1,
      OUT  = 2'd2
   } state_t;

   state_t                   state, state_nxt;
   logic [CANDIDATE_CNT-1:0] round_mask, mask_nxt;
   logic [CNT_W-1:0]         cnt, cnt_nxt;
   logic                     capture, err_set, out_clr, flush_req;
   logic [IDX_WIDTH-1:0]     win_idx;
   logic                     win_idx_ok;
   logic [CANDIDATE_CNT-1:0] slot_clr, slot_load;
   logic [KEY_WIDTH-1:0]     slot_key  [CANDIDATE_CNT];
   logic [DATA_WIDTH-1:0]    slot_data [CANDIDATE_CNT];

`ifdef BA_SCHED_FLUSH_EN
   assign flush_req = flush;
`else
   assign flush_req = 1'b0;
`endif

   assign win_idx    = agg_win_data[CW-1 -: IDX_WIDTH];
   assign win_idx_ok = ({1'b0, win_idx} < IDX_LIMIT);

   // Slot storage: occupied slots are immutable, so ready is simply "empty"
   assign req_rdy = flush_req ? '0 : ~slot_vld;

   always_comb begin
      slot_clr  = '0;
      slot_load = '0;
      for (int i = 0; i < CANDIDATE_CNT; i++) begin
         slot_load[i] = req_vld[i] && req_rdy[i];
         slot_clr[i]  = flush_req || (capture && win_idx_ok && (win_idx == IDX_WIDTH'(i)));
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         slot_vld <= '0;
      end else begin
         for (int i = 0; i < CANDIDATE_CNT; i++) begin
            if (slot_clr[i])
               slot_vld[i] <= 1'b0;
            else if (slot_load[i])
               slot_vld[i] <= 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      for (int i = 0; i < CANDIDATE_CNT; i++) begin
         if (slot_load[i]) begin
            slot_key[i]  <= req_key[i*KEY_WIDTH +: KEY_WIDTH];
            slot_data[i] <= req_data[i*DATA_WIDTH +: DATA_WIDTH];
         end
      end
   end

   // Candidate presentation: only the slots frozen into the round mask compete
   assign agg_cand_vld = round_mask;

   for (genvar g = 0; g < CANDIDATE_CNT; g++) begin : g_cand
      assign agg_cand_key[g*KEY_WIDTH +: KEY_WIDTH] = slot_key[g];
      assign agg_cand_data[g*CW +: CW]              = {IDX_WIDTH'(g), slot_data[g]};
   end

   // Round sequencing
   always_comb begin
      state_nxt = state;
      mask_nxt  = round_mask;
      cnt_nxt   = cnt;
      capture   = 1'b0;
      err_set   = 1'b0;
      out_clr   = 1'b0;
      unique case (state)
         IDLE: begin
            if (|slot_vld) begin
               mask_nxt  = slot_vld;
               cnt_nxt   = CNT_LOAD;
               state_nxt = EVAL;
            end
         end
         EVAL: begin
            if (cnt != '0) begin
               cnt_nxt = cnt - CNT_ONE;
            end else if (agg_win_vld) begin
               capture   = 1'b1;
               mask_nxt  = '0;
               state_nxt = OUT;
            end else begin
               err_set   = 1'b1;
               mask_nxt  = '0;
               state_nxt = IDLE;
            end
         end
         OUT: begin
            if (out_rdy) begin
               out_clr   = 1'b1;
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
      // A flush abandons any round in progress; a presented winner still waits for its handshake
      if (flush_req && (state != OUT)) begin
         state_nxt = IDLE;
         mask_nxt  = '0;
         cnt_nxt   = '0;
         capture   = 1'b0;
         err_set   = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         round_mask <= '0;
         cnt        <= '0;
         sched_err  <= 1'b0;
      end else begin
         state      <= state_nxt;
         round_mask <= mask_nxt;
         cnt        <= cnt_nxt;
         if (err_set || (capture && !win_idx_ok))
            sched_err <= 1'b1;
      end
   end

   // Winner output register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_vld  <= 1'b0;
         out_key  <= '0;
         out_data <= '0;
         out_idx  <= '0;
      end else if (capture) begin
         out_vld  <= 1'b1;
         out_key  <= agg_win_key;
         out_data <= agg_win_data[DATA_WIDTH-1:0];
         out_idx  <= win_idx;
      end else if (out_clr) begin
         out_vld  <= 1'b0;
      end
   end

endmodule

// File: tb/tb_binary_aggregator_sched.sv
// Testbench for binary_aggregator_sched: two-stage min-key aggregator model plus
// slot-level reference model; directed scenarios with randomized keys and payloads.
`timescale 1ns/1ps
module tb_binary_aggregator_sched;

   localparam int N   = 5;
   localparam int KW  = 6;
   localparam int DW  = 16;
   localparam int IW  = 3;
   localparam int LAT = 2;
   localparam int CW  = DW + IW;

   logic            clk = 1'b0;
   logic            rst_n;
   logic [N-1:0]    req_vld, req_rdy, agg_cand_vld, slot_vld;
   logic [N*KW-1:0] req_key, agg_cand_key;
   logic [N*DW-1:0] req_data;
   logic [N*CW-1:0] agg_cand_data;
   logic            agg_win_vld;
   logic [KW-1:0]   agg_win_key;
   logic [CW-1:0]   agg_win_data;
   logic            out_vld, out_rdy, sched_err;
   logic [KW-1:0]   out_key;
   logic [DW-1:0]   out_data;
   logic [IW-1:0]   out_idx;
`ifdef BA_SCHED_FLUSH_EN
   logic            flush;
`endif

   logic            force_inv, bad_idx;
   logic            c_vld, p1_vld, p2_vld;
   logic [KW-1:0]   c_key, p1_key, p2_key;
   logic [CW-1:0]   c_dat, p1_dat, p2_dat;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int last_out = 0;
   logic [N-1:0] m_vld;
   int m_key [N];
   int m_data[N];

   always #5 clk = ~clk;

   binary_aggregator_sched #(
      .CANDIDATE_CNT(N), .KEY_WIDTH(KW), .DATA_WIDTH(DW), .IDX_WIDTH(IW), .AGG_LATENCY(LAT)
   ) dut (
      .clk(clk), .rst_n(rst_n),
      .req_vld(req_vld), .req_key(req_key), .req_data(req_data), .req_rdy(req_rdy),
      .agg_cand_vld(agg_cand_vld), .agg_cand_key(agg_cand_key), .agg_cand_data(agg_cand_data),
      .agg_win_vld(agg_win_vld), .agg_win_key(agg_win_key), .agg_win_data(agg_win_data),
      .out_vld(out_vld), .out_key(out_key), .out_data(out_data), .out_idx(out_idx),
      .out_rdy(out_rdy),
`ifdef BA_SCHED_FLUSH_EN
      .flush(flush),
`endif
      .slot_vld(slot_vld), .sched_err(sched_err)
   );

   // Aggregator model: minimum key wins, equal keys go to the lower slot, LAT register stages
   always_comb begin
      c_vld = 1'b0;
      c_key = '0;
      c_dat = '0;
      for (int i = 0; i < N; i++) begin
         if (agg_cand_vld[i] && (!c_vld || (agg_cand_key[i*KW +: KW] < c_key))) begin
            c_vld = 1'b1;
            c_key = agg_cand_key[i*KW +: KW];
            c_dat = agg_cand_data[i*CW +: CW];
         end
      end
   end

   always @(posedge clk) begin
      p1_vld <= c_vld;  p1_key <= c_key;  p1_dat <= c_dat;
      p2_vld <= p1_vld; p2_key <= p1_key; p2_dat <= p1_dat;
   end

   assign agg_win_vld  = p2_vld && !force_inv;
   assign agg_win_key  = p2_key;
   assign agg_win_data = bad_idx ? {3'd7, p2_dat[DW-1:0]} : p2_dat;

   task automatic tick();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Expected winner among occupied slots: smallest key, lowest index on a tie
   function automatic int pick();
      int b;
      b = -1;
      for (int i = 0; i < N; i++)
         if (m_vld[i] && (b < 0 || m_key[i] < m_key[b])) b = i;
      return b;
   endfunction

   task automatic load(input logic [N-1:0] mask);
      for (int i = 0; i < N; i++) begin
         if (mask[i]) begin
            req_key[i*KW +: KW]  = KW'(m_key[i]);
            req_data[i*DW +: DW] = DW'(m_data[i]);
            m_vld[i] = 1'b1;
         end
      end
      req_vld = mask;
      tick();
      req_vld = '0;
   endtask

   task automatic wait_vld(input string tag);
      int n;
      n = 0;
      while (out_vld !== 1'b1 && n < 40) begin
         tick();
         n++;
      end
      chk({tag, "_vld"}, out_vld, 1);
   endtask

   task automatic expect_out(input string tag, input int idx, input int gap);
      wait_vld(tag);
      chk({tag, "_idx"}, out_idx, idx);
      chk({tag, "_key"}, out_key, m_key[idx]);
      chk({tag, "_data"}, out_data, m_data[idx]);
      if (gap > 0) chk({tag, "_gap"}, cyc - last_out, gap);
      last_out = cyc;
      m_vld[idx] = 1'b0;
   endtask

   task automatic drain(input string tag);
      int k;
      int idx;
      k = 0;
      while (m_vld != '0 && k < N) begin
         idx = pick();
         expect_out($sformatf("%s_%0d", tag, k), idx, (k == 0) ? 0 : LAT + 3);
         tick();
         k++;
      end
      chk({tag, "_empty"}, slot_vld, 0);
   endtask

   initial begin
      int k_old, d_old;
      int init_keys[N];
      rst_n = 1'b0; out_rdy = 1'b1; req_vld = '0; req_key = '0; req_data = '0;
      force_inv = 1'b0; bad_idx = 1'b0; m_vld = '0;
`ifdef BA_SCHED_FLUSH_EN
      flush = 1'b0;
`endif
      repeat (3) tick();
      chk("rst_slot_vld", slot_vld, 0);
      chk("rst_req_rdy", req_rdy, 5'h1F);
      chk("rst_cand_vld", agg_cand_vld, 0);
      chk("rst_out_vld", out_vld, 0);
      chk("rst_out_fields", {out_key, out_data, out_idx}, 0);
      chk("rst_err", sched_err, 0);
      rst_n = 1'b1;
      tick();

      // Single request: slot 2, key 5, payload 0xBEEF
      m_key[2] = 5; m_data[2] = 16'hBEEF;
      load(5'b00100);
      chk("t1_slot_vld", slot_vld, 5'b00100);
      chk("t1_req_rdy", req_rdy, 5'b11011);
      for (int c = 1; c < LAT + 3; c++) begin
         if (c == 2) begin
            chk("t1_cand_vld", agg_cand_vld, 5'b00100);
            chk("t1_cand_data", agg_cand_data[2*CW +: CW], {3'd2, 16'hBEEF});
         end
         chk($sformatf("t1_no_out_c%0d", c), out_vld, 0);
         tick();
      end
      chk("t1_out_vld", out_vld, 1);
      chk("t1_out_idx", out_idx, 2);
      chk("t1_out_key", out_key, 5);
      chk("t1_out_data", out_data, 16'hBEEF);
      chk("t1_slot_freed", slot_vld, 0);
      tick();
      chk("t1_out_done", out_vld, 0);

      // Full slot set with keys {9,3,7,3,1}: order 4,1,3,2,0
      init_keys = '{9, 3, 7, 3, 1};
      for (int i = 0; i < N; i++) begin
         m_key[i] = init_keys[i];
         m_data[i] = int'($urandom_range(0, 65535));
      end
      load(5'b11111);
      chk("t2_first_pick", pick(), 4);
      drain("t2_dir");

      for (int r = 0; r < 3; r++) begin
         for (int i = 0; i < N; i++) begin
            m_key[i] = int'($urandom_range(0, 7));
            m_data[i] = int'($urandom_range(0, 65535));
         end
         load(5'($urandom_range(1, 31)));
         drain($sformatf("t2_rnd%0d", r));
      end

      // Slot loaded mid-round is deferred to the next round
      m_key[1] = int'($urandom_range(0, 63)); m_data[1] = int'($urandom_range(0, 65535));
      m_key[3] = 0; m_data[3] = int'($urandom_range(0, 65535));
      load(5'b00010);
      tick();
      load(5'b01000);
      chk("t3_cand_vld", agg_cand_vld, 5'b00010);
      chk("t3_slot_vld", slot_vld, 5'b01010);
      expect_out("t3_a", 1, 0);
      tick();
      expect_out("t3_b", 3, LAT + 3);
      tick();

      // Downstream stall with reload of the freed slot
      out_rdy = 1'b0;
      m_key[0] = int'($urandom_range(0, 63)); m_data[0] = int'($urandom_range(0, 65535));
      load(5'b00001);
      expect_out("t4_first", 0, 0);
      k_old = m_key[0]; d_old = m_data[0];
      chk("t4_rdy_freed", req_rdy[0], 1);
      chk("t4_slot_freed", slot_vld[0], 0);
      m_key[0] = int'($urandom_range(0, 63)); m_data[0] = int'($urandom_range(0, 65535));
      load(5'b00001);
      chk("t4_reload", slot_vld[0], 1);
      for (int s = 0; s < 10; s++) begin
         chk($sformatf("t4_hold%0d", s), {out_vld, out_key, out_data, out_idx},
             {1'b1, KW'(k_old), DW'(d_old), 3'd0});
         tick();
      end
      out_rdy = 1'b1;
      tick();
      chk("t4_released", out_vld, 0);
      expect_out("t4_second", 0, 0);
      tick();

      // Aggregator withholds its winner: sticky error, slot retained, retried
      force_inv = 1'b1;
      m_key[4] = int'($urandom_range(0, 63)); m_data[4] = int'($urandom_range(0, 65535));
      load(5'b10000);
      repeat (LAT + 1) tick();
      chk("t5_err_pre", sched_err, 0);
      tick();
      chk("t5_err", sched_err, 1);
      chk("t5_no_out", out_vld, 0);
      chk("t5_slots", slot_vld, 5'b10000);
      force_inv = 1'b0;
      expect_out("t5_retry", 4, 0);
      tick();
      chk("t5_err_sticky", sched_err, 1);

      // Asynchronous reset in the middle of a round
      m_key[0] = 3; m_key[1] = 4; m_data[0] = 1; m_data[1] = 2;
      load(5'b00011);
      tick();
      rst_n = 1'b0;
      #1;
      chk("t6_slot_vld", slot_vld, 0);
      chk("t6_req_rdy", req_rdy, 5'h1F);
      chk("t6_cand_vld", agg_cand_vld, 0);
      chk("t6_out_vld", out_vld, 0);
      chk("t6_out_fields", {out_key, out_data, out_idx}, 0);
      chk("t6_err", sched_err, 0);
      m_vld = '0;
      tick();
      rst_n = 1'b1;
      tick();

      // Out-of-range winner index: presented, flagged, slot kept
      bad_idx = 1'b1;
      m_key[2] = int'($urandom_range(0, 63)); m_data[2] = int'($urandom_range(0, 65535));
      load(5'b00100);
      wait_vld("t7_bad");
      chk("t7_idx", out_idx, 7);
      chk("t7_key", out_key, m_key[2]);
      chk("t7_data", out_data, m_data[2]);
      chk("t7_err", sched_err, 1);
      chk("t7_slot_kept", slot_vld, 5'b00100);
      bad_idx = 1'b0;
      tick();
      expect_out("t7_retry", 2, 0);
      tick();
      chk("t7_empty", slot_vld, 0);

`ifdef BA_SCHED_FLUSH_EN
      for (int i = 0; i < 3; i++) begin
         m_key[i] = int'($urandom_range(0, 63)); m_data[i] = int'($urandom_range(0, 65535));
      end
      load(5'b00111);
      tick();
      flush = 1'b1;
      #1;
      chk("t8_rdy_flush", req_rdy, 0);
      tick();
      flush = 1'b0;
      m_vld = '0;
      chk("t8_slots", slot_vld, 0);
      chk("t8_cand", agg_cand_vld, 0);
      for (int c = 0; c < LAT + 3; c++) begin
         chk($sformatf("t8_no_out%0d", c), out_vld, 0);
         tick();
      end
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: observed timeout, expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule
